alu_wide_sequencer: RTL and testbench
=====================================

ALU_WIDE_SEQUENCER -- requirements
Module: alu_wide_sequencer

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 cmd_valid  input  1  command offered.
REQ-004 cmd_ready  output  1  sequencer accepts command this cycle.
REQ-005 cmd_op  input  2  00 sum, 01 xor, 10 and, 11 or.
REQ-006 cmd_a, cmd_b  input  64 each  operands.
REQ-007 cmd_cin  input  1  carry-in for sum.
REQ-008 ALUMODE  output  4, OPMODE  output  9, USE_SIMD  output  1  ALU control.
REQ-009 X, Y, Z, W  output  32 each  ALU operands; CIN  output  1  ALU carry-in.
REQ-010 S  input  32, alu_carry_out  input  1  combinational ALU result and carry.
REQ-011 res_valid  output  1, res_ready  input  1  result handshake.
REQ-012 res_data  output  64, res_carry  output  1  result and final carry.

Function
REQ-013 FSM states IDLE, LO, HI, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-014 IDLE: cmd_valid=1 registers cmd_op/a/b/cin, next state LO; else stay.
REQ-015 LO: X=a[31:0], Y=b[31:0], CIN=cin (sum) or 0 (logic); S captured into res_data[31:0], alu_carry_out into carry register; next HI.
REQ-016 HI: X=a[63:32], Y=b[63:32], CIN=carry register (sum) or 0 (logic); S captured into res_data[63:32]; res_carry = alu_carry_out for sum, 0 for logic; next DONE.
REQ-017 DONE: res_valid=1, res_data/res_carry stable; res_ready=1 returns to IDLE next cycle; otherwise hold indefinitely.
REQ-018 Op mapping: sum ALUMODE=0000; xor 0100; and 1100 with OPMODE[3]=0; or 1100 with OPMODE[3]=1; all other OPMODE bits 0.
REQ-019 USE_SIMD SHALL be 0 (single 32-bit lane) in every state; Z=W=0 in every state.
REQ-020 Outside LO/HI, X=Y=0, CIN=0, ALUMODE=0000, OPMODE=0.
REQ-021 Latency: command accepted cycle T -> res_valid asserted cycle T+3 (no-narrow path).
REQ-022 Sum arithmetic modulo 2^64; res_carry = bit 64 of a+b+cin.
REQ-023 No new command accepted while LO/HI/DONE; back-to-back throughput one command per 4 cycles when res_ready held 1.

Reset
REQ-024 reset=1 SHALL force IDLE, cmd_ready=1 after release, res_valid=0, res_data=0, res_carry=0, carry register 0.
REQ-025 reset asserted in LO/HI/DONE SHALL discard the in-flight command; no res_valid for it.

Configuration
REQ-026 Macro ALU_SEQ_NARROW_EN: when defined, adds input cmd_narrow (1 bit, registered with command); narrow command goes LO->DONE, res_data[63:32]=0, res_carry=LO alu_carry_out (sum) or 0, latency T+2.
REQ-027 Without ALU_SEQ_NARROW_EN, cmd_narrow port SHALL not exist and every command uses LO->HI->DONE.

Verification
REQ-028 sum a=0x00000000_FFFFFFFF, b=1, cin=0 -> LO CIN=0, HI CIN=1; res_data=0x00000001_00000000, res_carry=0, res_valid at T+3.
REQ-029 sum a=b=0xFFFFFFFF_FFFFFFFF, cin=1 -> res_data=0xFFFFFFFF_FFFFFFFF, res_carry=1.
REQ-030 or a=0xF0F0..., b=0x0F0F... -> ALUMODE=1100, OPMODE[3]=1 in LO/HI, res_data=all ones, res_carry=0.
REQ-031 res_ready held 0 for 5 cycles in DONE -> res_valid and res_data stable, cmd_ready=0, new cmd_valid ignored.
REQ-032 reset pulsed during HI -> next cycle IDLE, res_valid=0, res_data=0; following command completes normally.
REQ-033 ALU_SEQ_NARROW_EN defined, narrow sum a=0xFFFFFFFF, b=1 -> res_data=0, res_carry=1, res_valid at T+2.

Source files
------------

// File: rtl/alu_wide_sequencer.sv
// Sequences a 64-bit sum/xor/and/or through a 32-bit external ALU in two halves (LO then HI).
// Optional macro ALU_SEQ_NARROW_EN adds cmd_narrow: a single 32-bit pass that skips HI.
module alu_wide_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [63:0] cmd_a,
  input  logic [63:0] cmd_b,
  input  logic        cmd_cin,
`ifdef ALU_SEQ_NARROW_EN
  input  logic        cmd_narrow,
`endif
  output logic [3:0]  ALUMODE,
  output logic [8:0]  OPMODE,
  output logic        USE_SIMD,
  output logic [31:0] X,
  output logic [31:0] Y,
  output logic [31:0] Z,
  output logic [31:0] W,
  output logic        CIN,
  input  logic [31:0] S,
  input  logic        alu_carry_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        res_carry
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  typedef enum logic [1:0] {OP_SUM = 2'b00, OP_XOR = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11} op_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic        r_narrow;
  logic [31:0] r_aHi;
  logic [31:0] r_bHi;
  logic        r_carry;
  logic        r_cmdReady;
  logic        r_resValid;
  logic [63:0] r_resData;
  logic        r_resCarry;
  logic [3:0]  r_aluMode;
  logic [8:0]  r_opMode;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic        r_cin;
  logic        w_isSum;

  function automatic logic [3:0] aluModeFor(input logic [1:0] op);
    case (op)
      OP_SUM:  aluModeFor = 4'b0000;
      OP_XOR:  aluModeFor = 4'b0100;
      default: aluModeFor = 4'b1100;
    endcase
  endfunction

  // and/or share ALUMODE 1100; OPMODE[3] selects or
  function automatic logic [8:0] opModeFor(input logic [1:0] op);
    opModeFor = (op == OP_OR) ? 9'h008 : 9'h000;
  endfunction

  assign w_isSum = (r_op == OP_SUM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_op       <= 2'b00;
      r_narrow   <= 1'b0;
      r_aHi      <= '0;
      r_bHi      <= '0;
      r_carry    <= 1'b0;
      r_cmdReady <= 1'b1;
      r_resValid <= 1'b0;
      r_resData  <= '0;
      r_resCarry <= 1'b0;
      r_aluMode  <= '0;
      r_opMode   <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_cin      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op       <= cmd_op;
`ifdef ALU_SEQ_NARROW_EN
            r_narrow   <= cmd_narrow;
`else
            r_narrow   <= 1'b0;
`endif
            r_aHi      <= cmd_a[63:32];
            r_bHi      <= cmd_b[63:32];
            r_x        <= cmd_a[31:0];
            r_y        <= cmd_b[31:0];
            r_cin      <= (cmd_op == OP_SUM) ? cmd_cin : 1'b0;
            r_aluMode  <= aluModeFor(cmd_op);
            r_opMode   <= opModeFor(cmd_op);
            r_cmdReady <= 1'b0;
            r_state    <= LO;
          end
        end
        LO: begin
          r_resData[31:0] <= S;
          r_carry         <= alu_carry_out;
          if (r_narrow) begin
            r_resData[63:32] <= '0;
            r_resCarry       <= w_isSum ? alu_carry_out : 1'b0;
            r_resValid       <= 1'b1;
            r_x              <= '0;
            r_y              <= '0;
            r_cin            <= 1'b0;
            r_aluMode        <= '0;
            r_opMode         <= '0;
            r_state          <= DONE;
          end else begin
            // Upper half rides on the carry just produced by the lower half
            r_x     <= r_aHi;
            r_y     <= r_bHi;
            r_cin   <= w_isSum ? alu_carry_out : 1'b0;
            r_state <= HI;
          end
        end
        HI: begin
          r_resData[63:32] <= S;
          r_resCarry       <= w_isSum ? alu_carry_out : 1'b0;
          r_resValid       <= 1'b1;
          r_x              <= '0;
          r_y              <= '0;
          r_cin            <= 1'b0;
          r_aluMode        <= '0;
          r_opMode         <= '0;
          r_state          <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            r_resValid <= 1'b0;
            r_cmdReady <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmdReady;
  assign res_valid = r_resValid;
  assign res_data  = r_resData;
  assign res_carry = r_resCarry;
  assign ALUMODE   = r_aluMode;
  assign OPMODE    = r_opMode;
  assign X         = r_x;
  assign Y         = r_y;
  assign CIN       = r_cin;
  assign USE_SIMD  = 1'b0;
  assign Z         = '0;
  assign W         = '0;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer: behavioural 32-bit ALU plus a result scoreboard.
// Narrow-command step is built only when ALU_SEQ_NARROW_EN is defined.
module tb_alu_wide_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [63:0] cmd_a;
  logic [63:0] cmd_b;
  logic        cmd_cin;
`ifdef ALU_SEQ_NARROW_EN
  logic        cmd_narrow;
`endif
  logic [3:0]  ALUMODE;
  logic [8:0]  OPMODE;
  logic        USE_SIMD;
  logic [31:0] X, Y, Z, W;
  logic        CIN;
  logic [31:0] S;
  logic        alu_carry_out;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        res_carry;

  typedef struct {
    logic [63:0] data;
    logic        carry;
  } result_t;

  result_t expQ[$];
  int      testsRun  = 0;
  int      failCount = 0;

  alu_wide_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
`ifdef ALU_SEQ_NARROW_EN
    .cmd_narrow(cmd_narrow),
`endif
    .ALUMODE(ALUMODE), .OPMODE(OPMODE), .USE_SIMD(USE_SIMD),
    .X(X), .Y(Y), .Z(Z), .W(W), .CIN(CIN),
    .S(S), .alu_carry_out(alu_carry_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry)
  );

  always #5 clk = ~clk;

  // External 32-bit ALU as the sequencer expects to drive it
  logic [32:0] aluSum;
  always_comb begin
    aluSum        = {1'b0, X} + {1'b0, Y} + {32'b0, CIN};
    S             = '0;
    alu_carry_out = 1'b0;
    case (ALUMODE)
      4'b0000: {alu_carry_out, S} = aluSum;
      4'b0100: S = X ^ Y;
      4'b1100: S = OPMODE[3] ? (X | Y) : (X & Y);
      default: S = '0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] expAluMode(input logic [1:0] op);
    case (op)
      2'b00:   return 4'b0000;
      2'b01:   return 4'b0100;
      default: return 4'b1100;
    endcase
  endfunction

  function automatic result_t expResult(input logic [1:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input logic cin, input logic narrow);
    result_t     r;
    logic [64:0] full;
    logic [32:0] lo;
    full = {1'b0, a} + {1'b0, b} + {64'b0, cin};
    lo   = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'b0, cin};
    r.carry = 1'b0;
    case (op)
      2'b00: begin
        r.data  = narrow ? {32'b0, lo[31:0]} : full[63:0];
        r.carry = narrow ? lo[32] : full[64];
      end
      2'b01:   r.data = a ^ b;
      2'b10:   r.data = a & b;
      default: r.data = a | b;
    endcase
    if (narrow) r.data[63:32] = '0;
    return r;
  endfunction

  // Offers one command, pushes its expected result, returns in the LO cycle
  task automatic applyStimulus(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                               input logic cin, input logic narrow);
    int waitCnt = 0;
    while (cmd_ready !== 1'b1 && waitCnt < 20) begin
      stepCycle();
      waitCnt++;
    end
    checkOutput("cmdReadyBeforeAccept", {63'b0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_cin   = cin;
`ifdef ALU_SEQ_NARROW_EN
    cmd_narrow = narrow;
`endif
    expQ.push_back(expResult(op, a, b, cin, narrow));
    stepCycle();
    cmd_valid = 1'b0;
  endtask

  task automatic checkAluControls(input string tag, input logic [31:0] x, input logic [31:0] y,
                                  input logic cin, input logic [3:0] mode, input logic [8:0] opm);
    checkOutput({tag, "_X"}, {32'b0, X}, {32'b0, x});
    checkOutput({tag, "_Y"}, {32'b0, Y}, {32'b0, y});
    checkOutput({tag, "_ctrl"}, {50'b0, ALUMODE, OPMODE, CIN},
                {50'b0, mode, opm, cin});
    checkOutput({tag, "_ZWsimd"}, {31'b0, USE_SIMD, Z | W}, 64'd0);
    checkOutput({tag, "_busy"}, {62'b0, cmd_ready, res_valid}, 64'd0);
  endtask

  // Walks LO (and HI) from the LO cycle, ending in the DONE cycle
  task automatic checkPhases(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                             input logic cin, input logic narrow);
    logic [32:0] lo;
    logic [8:0]  opm;
    lo  = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'b0, cin};
    opm = (op == 2'b11) ? 9'h008 : 9'h000;
    checkAluControls("lo", a[31:0], b[31:0], (op == 2'b00) ? cin : 1'b0, expAluMode(op), opm);
    stepCycle();
    if (!narrow) begin
      checkAluControls("hi", a[63:32], b[63:32], (op == 2'b00) ? lo[32] : 1'b0, expAluMode(op), opm);
      stepCycle();
    end
    checkOutput("latencyResValid", {63'b0, res_valid}, 64'd1);
  endtask

  task automatic collectResult(output result_t got);
    result_t e;
    int      waitCnt = 0;
    while (res_valid !== 1'b1 && waitCnt < 10) begin
      stepCycle();
      waitCnt++;
    end
    got.data  = res_data;
    got.carry = res_carry;
    if (expQ.size() == 0) begin
      checkOutput("scoreboardEmpty", 64'd1, 64'd0);
    end else begin
      e = expQ.pop_front();
      checkOutput("resData", res_data, e.data);
      checkOutput("resCarry", {63'b0, res_carry}, {63'b0, e.carry});
      checkOutput("doneCtrlIdle", {X, Y} | {50'b0, ALUMODE, OPMODE, CIN}, 64'd0);
    end
  endtask

  task automatic runCommand(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                            input logic cin, input logic narrow);
    result_t got;
    applyStimulus(op, a, b, cin, narrow);
    checkPhases(op, a, b, cin, narrow);
    collectResult(got);
    stepCycle();
    checkOutput("backToIdle", {62'b0, cmd_ready, res_valid}, 64'd2);
  endtask

  initial begin
    result_t held;
    logic [63:0] rndA, rndB;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_cin   = 1'b0;
`ifdef ALU_SEQ_NARROW_EN
    cmd_narrow = 1'b0;
`endif
    res_ready = 1'b1;
    repeat (3) stepCycle();
    reset = 1'b0;
    stepCycle();
    checkOutput("resetCmdReady", {63'b0, cmd_ready}, 64'd1);
    checkOutput("resetResValid", {63'b0, res_valid}, 64'd0);
    checkOutput("resetResData", res_data, 64'd0);
    checkOutput("resetResCarry", {63'b0, res_carry}, 64'd0);
    checkOutput("resetAluCtrl", {X, Y} | {50'b0, ALUMODE, OPMODE, CIN}, 64'd0);

    runCommand(2'b00, 64'h00000000_FFFFFFFF, 64'd1, 1'b0, 1'b0);
    runCommand(2'b00, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0);
    runCommand(2'b11, 64'hF0F0F0F0_F0F0F0F0, 64'h0F0F0F0F_0F0F0F0F, 1'b0, 1'b0);
    rndA = {$urandom, $urandom};
    rndB = {$urandom, $urandom};
    runCommand(2'b01, rndA, rndB, 1'b1, 1'b0);
    runCommand(2'b10, rndA, rndB, 1'b0, 1'b0);
    runCommand(2'b11, rndA, rndB, 1'b1, 1'b0);
    runCommand(2'b00, rndA, rndB, 1'b1, 1'b0);

    // Stall in DONE: result must hold and new offers must be ignored
    res_ready = 1'b0;
    applyStimulus(2'b00, 64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 1'b1, 1'b0);
    checkPhases(2'b00, 64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 1'b1, 1'b0);
    collectResult(held);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_a     = {$urandom, $urandom};
      stepCycle();
      checkOutput("stallResValid", {63'b0, res_valid}, 64'd1);
      checkOutput("stallResData", res_data, held.data);
      checkOutput("stallCmdReady", {63'b0, cmd_ready}, 64'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    stepCycle();
    checkOutput("stallRelease", {62'b0, cmd_ready, res_valid}, 64'd2);
    stepCycle();
    checkOutput("idleStays", {62'b0, cmd_ready, res_valid}, 64'd2);

    // Reset during HI discards the in-flight command
    applyStimulus(2'b00, 64'hAAAAAAAA_55555555, 64'h11111111_22222222, 1'b0, 1'b0);
    stepCycle();
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    void'(expQ.pop_back());
    checkOutput("midResetResValid", {63'b0, res_valid}, 64'd0);
    checkOutput("midResetResData", res_data, 64'd0);
    checkOutput("midResetCmdReady", {63'b0, cmd_ready}, 64'd1);
    repeat (3) begin
      stepCycle();
      checkOutput("noGhostResult", {63'b0, res_valid}, 64'd0);
    end
    runCommand(2'b00, 64'h00000001_80000000, 64'h00000002_80000000, 1'b1, 1'b0);

`ifdef ALU_SEQ_NARROW_EN
    runCommand(2'b00, 64'h00000000_FFFFFFFF, 64'd1, 1'b0, 1'b1);
    runCommand(2'b01, 64'hDEADBEEF_CAFEF00D, 64'h01234567_89ABCDEF, 1'b0, 1'b1);
`endif

    checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
